// File: rtl/md_pkg.sv
// Shared types and constants for the MULT/DIV sequencer.
package md_pkg;

   localparam int MD_WIDTH = 32;
   localparam int MD_ITERS = 32;

   localparam logic MD_MULT = 1'b0;
   localparam logic MD_DIV  = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Absolute value of a two's-complement operand; unsigned operands pass through.
   function automatic logic [MD_WIDTH-1:0] magnitude(input logic [MD_WIDTH-1:0] v,
                                                      input logic              is_signed);
      if (is_signed && v[MD_WIDTH-1]) begin
         return ~v + 32'd1;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// Operation request / result bundle between the pipeline and the MULT/DIV sequencer.
interface md_sequencer_if;
   import md_pkg::*;

   logic                start;
   logic                op;
   logic                is_unsigned;
   logic [MD_WIDTH-1:0] a;
   logic [MD_WIDTH-1:0] b;
   logic                busy;
   logic                stall;
   logic                done;
   logic                div_zero;
   logic [MD_WIDTH-1:0] hi;
   logic [MD_WIDTH-1:0] lo;

   modport master (output start, op, is_unsigned, a, b,
                   input  busy, stall, done, div_zero, hi, lo);
   modport slave  (input  start, op, is_unsigned, a, b,
                   output busy, stall, done, div_zero, hi, lo);
endinterface

// File: rtl/md_iter_unit.sv
// One iteration of shift-add multiply or restoring divide on operand magnitudes.
module md_iter_unit
   import md_pkg::*;
(
   input  logic                  op,
   input  logic [2*MD_WIDTH-1:0] acc,
   input  logic [2*MD_WIDTH-1:0] mc,
   input  logic [MD_WIDTH-1:0]   mq,
   output logic [2*MD_WIDTH-1:0] acc_nxt,
   output logic [2*MD_WIDTH-1:0] mc_nxt,
   output logic [MD_WIDTH-1:0]   mq_nxt
);

   logic [MD_WIDTH:0]   rem_sh_s;
   logic [MD_WIDTH+1:0] diff_s;

   // DIV: acc[32:0] is the partial remainder, mq shifts dividend out and quotient in.
   assign rem_sh_s = {acc[MD_WIDTH-1:0], mq[MD_WIDTH-1]};
   assign diff_s   = {1'b0, rem_sh_s} - {2'b00, mc[MD_WIDTH-1:0]};

   // Single-step datapath for the selected operation.
   always_comb begin
      acc_nxt = acc;
      mc_nxt  = mc;
      mq_nxt  = mq;
      case (op)
         MD_MULT: begin
            if (mq[0]) begin
               acc_nxt = acc + mc;
            end else begin
               acc_nxt = acc;
            end
            mc_nxt = {mc[2*MD_WIDTH-2:0], 1'b0};
            mq_nxt = {1'b0, mq[MD_WIDTH-1:1]};
         end
         MD_DIV: begin
            if (!diff_s[MD_WIDTH+1]) begin
               acc_nxt = {31'd0, diff_s[MD_WIDTH:0]};
               mq_nxt  = {mq[MD_WIDTH-2:0], 1'b1};
            end else begin
               acc_nxt = {31'd0, rem_sh_s};
               mq_nxt  = {mq[MD_WIDTH-2:0], 1'b0};
            end
         end
         default: begin
            acc_nxt = acc;
            mc_nxt  = mc;
            mq_nxt  = mq;
         end
      endcase
   end

endmodule

// File: rtl/md_sequencer.sv
// Iterative MULT/DIV sequencer: IDLE -> RUN x32 -> FIX (signs) -> DONE.
// Optional MD_EARLY_TERM_EN ends MULT once the remaining multiplier magnitude is zero.
module md_sequencer
   import md_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   md_sequencer_if.slave  bus
);

   state_t                state_r, state_nxt_s;
   logic [4:0]            cnt_r;
   logic                  op_r, neg_r, rneg_r, dz_r;
   logic [MD_WIDTH-1:0]   a_r;
   logic [2*MD_WIDTH-1:0] acc_r, mc_r, acc_nxt_s, mc_nxt_s;
   logic [MD_WIDTH-1:0]   mq_r, mq_nxt_s;
   logic [MD_WIDTH-1:0]   hi_r, lo_r, fix_hi_s, fix_lo_s;
   logic                  div_zero_r;
   logic                  accept_s, last_s, early_s, div_by_zero_s;
   logic [MD_WIDTH-1:0]   mag_a_s, mag_b_s;
   logic [2*MD_WIDTH-1:0] prod_s;
   logic [MD_WIDTH-1:0]   quo_s, rem_s;

   assign accept_s      = bus.start && ((state_r == IDLE) || (state_r == DONE));
   assign div_by_zero_s = (bus.op == MD_DIV) && (bus.b == 32'd0);
   assign mag_a_s       = magnitude(bus.a, !bus.is_unsigned);
   assign mag_b_s       = magnitude(bus.b, !bus.is_unsigned);

   md_iter_unit u_iter (
      .op      (op_r),
      .acc     (acc_r),
      .mc      (mc_r),
      .mq      (mq_r),
      .acc_nxt (acc_nxt_s),
      .mc_nxt  (mc_nxt_s),
      .mq_nxt  (mq_nxt_s)
   );

`ifdef MD_EARLY_TERM_EN
   assign early_s = (op_r == MD_MULT) && (mq_nxt_s == 32'd0);
`else
   assign early_s = 1'b0;
`endif
   assign last_s = (cnt_r == 5'(MD_ITERS - 1)) || early_s;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; a zero divisor bypasses RUN entirely.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE, DONE: begin
            if (accept_s) begin
               state_nxt_s = div_by_zero_s ? FIX : RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_nxt_s = FIX;
            end else begin
               state_nxt_s = RUN;
            end
         end
         FIX:     state_nxt_s = DONE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Operand capture at acceptance and iteration state while running.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r  <= 5'd0;
         op_r   <= MD_MULT;
         neg_r  <= 1'b0;
         rneg_r <= 1'b0;
         dz_r   <= 1'b0;
         a_r    <= 32'd0;
         acc_r  <= 64'd0;
         mc_r   <= 64'd0;
         mq_r   <= 32'd0;
      end else if (accept_s) begin
         cnt_r  <= 5'd0;
         op_r   <= bus.op;
         neg_r  <= !bus.is_unsigned && (bus.a[MD_WIDTH-1] ^ bus.b[MD_WIDTH-1]);
         rneg_r <= !bus.is_unsigned && bus.a[MD_WIDTH-1];
         dz_r   <= div_by_zero_s;
         a_r    <= bus.a;
         acc_r  <= 64'd0;
         mc_r   <= {32'd0, (bus.op == MD_MULT) ? mag_a_s : mag_b_s};
         mq_r   <= (bus.op == MD_MULT) ? mag_b_s : mag_a_s;
      end else if (state_r == RUN) begin
         cnt_r  <= cnt_r + 5'd1;
         acc_r  <= acc_nxt_s;
         mc_r   <= mc_nxt_s;
         mq_r   <= mq_nxt_s;
      end
   end

   // Sign correction: remainder follows the dividend, product/quotient follow sign xor.
   always_comb begin
      prod_s   = neg_r  ? (~acc_r + 64'd1) : acc_r;
      quo_s    = neg_r  ? (~mq_r + 32'd1) : mq_r;
      rem_s    = rneg_r ? (~acc_r[MD_WIDTH-1:0] + 32'd1) : acc_r[MD_WIDTH-1:0];
      fix_hi_s = 32'd0;
      fix_lo_s = 32'd0;
      if (dz_r) begin
         fix_hi_s = a_r;
         fix_lo_s = 32'hFFFF_FFFF;
      end else if (op_r == MD_MULT) begin
         fix_hi_s = prod_s[2*MD_WIDTH-1:MD_WIDTH];
         fix_lo_s = prod_s[MD_WIDTH-1:0];
      end else begin
         fix_hi_s = rem_s;
         fix_lo_s = quo_s;
      end
   end

   // Result registers load only on the FIX -> DONE transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_r       <= 32'd0;
         lo_r       <= 32'd0;
         div_zero_r <= 1'b0;
      end else if (state_r == FIX) begin
         hi_r       <= fix_hi_s;
         lo_r       <= fix_lo_s;
         div_zero_r <= dz_r;
      end
   end

   assign bus.busy     = (state_r == RUN) || (state_r == FIX);
   assign bus.stall    = bus.busy || accept_s;
   assign bus.done     = (state_r == DONE);
   assign bus.hi       = hi_r;
   assign bus.lo       = lo_r;
   assign bus.div_zero = div_zero_r;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer; cycle 0 is the start-accept cycle.
module tb_md_sequencer;
   import md_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   passed = 0;

   md_sequencer_if bus ();

   md_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

`ifdef MD_EARLY_TERM_EN
   localparam int MUL2_DONE  = 4;
   localparam int MUL2_BLAST = 3;
   localparam int MUL5_DONE  = 5;
`else
   localparam int MUL2_DONE  = 34;
   localparam int MUL2_BLAST = 33;
   localparam int MUL5_DONE  = 34;
`endif

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Issue one op in cycle 0, run to the DONE cycle (bounded), report timing.
   task automatic do_op(input logic o, input logic u, input logic [31:0] av, input logic [31:0] bv,
                        output int dcyc, output int bfirst, output int blast);
      bus.start = 1'b1;
      bus.op = o;
      bus.is_unsigned = u;
      bus.a = av;
      bus.b = bv;
      #1;
      chk("stall_on_start", {63'd0, bus.stall}, 64'd1);
      chk("busy_on_start", {63'd0, bus.busy}, 64'd0);
      step();
      bus.start = 1'b0;
      bus.a = 32'hDEAD_BEEF;
      bus.b = 32'h0000_0000;
      dcyc = -1;
      bfirst = -1;
      blast = -1;
      for (int c = 1; c <= 80; c++) begin
         if (bus.busy) begin
            if (bfirst < 0) bfirst = c;
            blast = c;
         end
         if (bus.done) begin
            dcyc = c;
            break;
         end
         step();
      end
   endtask

   initial begin
      int dc, bf, bl, seen, d1, d2;
      bus.start = 1'b0;
      bus.op = MD_MULT;
      bus.is_unsigned = 1'b1;
      bus.a = 32'd0;
      bus.b = 32'd0;
      reset = 1'b1;
      step();
      step();
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_stall", {63'd0, bus.stall}, 64'd0);
      chk("rst_done", {63'd0, bus.done}, 64'd0);
      chk("rst_dz", {63'd0, bus.div_zero}, 64'd0);
      chk("rst_hi", {32'd0, bus.hi}, 64'd0);
      chk("rst_lo", {32'd0, bus.lo}, 64'd0);
      reset = 1'b0;
      step();

      // Unsigned 0xFFFFFFFF * 2
      do_op(MD_MULT, 1'b1, 32'hFFFF_FFFF, 32'd2, dc, bf, bl);
      chk("mulu_done_cyc", 64'(dc), 64'(MUL2_DONE));
      chk("mulu_busy_first", 64'(bf), 64'd1);
      chk("mulu_busy_last", 64'(bl), 64'(MUL2_BLAST));
      chk("mulu_hi", {32'd0, bus.hi}, 64'h0000_0001);
      chk("mulu_lo", {32'd0, bus.lo}, 64'hFFFF_FFFE);
      chk("mulu_dz", {63'd0, bus.div_zero}, 64'd0);
      step();
      chk("done_one_cycle", {63'd0, bus.done}, 64'd0);

      // Signed -3 * 5
      do_op(MD_MULT, 1'b0, 32'hFFFF_FFFD, 32'd5, dc, bf, bl);
      chk("muls_done_cyc", 64'(dc), 64'(MUL5_DONE));
      chk("muls_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
      chk("muls_lo", {32'd0, bus.lo}, 64'hFFFF_FFF1);
      step();

      // Signed -7 / 2
      do_op(MD_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, dc, bf, bl);
      chk("divs_done_cyc", 64'(dc), 64'd34);
      chk("divs_lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);
      chk("divs_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
      chk("divs_dz", {63'd0, bus.div_zero}, 64'd0);
      step();

      // Divide by zero
      do_op(MD_DIV, 1'b1, 32'h0000_1234, 32'd0, dc, bf, bl);
      chk("div0_done_cyc", 64'(dc), 64'd2);
      chk("div0_lo", {32'd0, bus.lo}, 64'hFFFF_FFFF);
      chk("div0_hi", {32'd0, bus.hi}, 64'h0000_1234);
      chk("div0_dz", {63'd0, bus.div_zero}, 64'd1);
      step();
      chk("div0_hold_hi", {32'd0, bus.hi}, 64'h0000_1234);
      chk("div0_hold_done", {63'd0, bus.done}, 64'd0);

      // Signed overflow 0x80000000 / -1 wraps
      do_op(MD_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, dc, bf, bl);
      chk("divovf_done_cyc", 64'(dc), 64'd34);
      chk("divovf_lo", {32'd0, bus.lo}, 64'h8000_0000);
      chk("divovf_hi", {32'd0, bus.hi}, 64'h0000_0000);
      chk("divovf_dz", {63'd0, bus.div_zero}, 64'd0);
      step();

      // Reset in cycle 10 of a MULT, with start also asserted (must be overridden)
      bus.start = 1'b1;
      bus.op = MD_MULT;
      bus.is_unsigned = 1'b1;
      bus.a = 32'd3;
      bus.b = 32'h8000_0001;
      step();
      bus.start = 1'b0;
      seen = 0;
      for (int c = 1; c <= 9; c++) begin
         if (bus.done) seen++;
         step();
      end
      chk("rstrun_busy_c10", {63'd0, bus.busy}, 64'd1);
      reset = 1'b1;
      bus.start = 1'b1;
      step();
      reset = 1'b0;
      bus.start = 1'b0;
      #1;
      if (bus.done) seen++;
      chk("rstrun_busy_c11", {63'd0, bus.busy}, 64'd0);
      chk("rstrun_stall_c11", {63'd0, bus.stall}, 64'd0);
      chk("rstrun_hi_c11", {32'd0, bus.hi}, 64'd0);
      chk("rstrun_lo_c11", {32'd0, bus.lo}, 64'd0);
      chk("rstrun_no_done", 64'(seen), 64'd0);
      step();
      do_op(MD_MULT, 1'b1, 32'd3, 32'h8000_0001, dc, bf, bl);
      chk("rstrun_new_done_cyc", 64'(12 + dc), 64'd46);
      chk("rstrun_new_hi", {32'd0, bus.hi}, 64'h0000_0001);
      chk("rstrun_new_lo", {32'd0, bus.lo}, 64'h8000_0003);
      step();

      // Back-to-back: start ignored in RUN, held start in DONE accepted
      d1 = -1;
      d2 = -1;
      for (int c = 0; c <= 80; c++) begin
         bus.start = 1'b0;
         if (c == 0) begin
            bus.start = 1'b1; bus.op = MD_DIV; bus.is_unsigned = 1'b0;
            bus.a = 32'hFFFF_FFF9; bus.b = 32'd2;
         end else if (c == 5) begin
            bus.start = 1'b1; bus.op = MD_DIV; bus.is_unsigned = 1'b1;
            bus.a = 32'h0000_0055; bus.b = 32'd0;
         end else if (c == 34) begin
            bus.start = 1'b1; bus.op = MD_DIV; bus.is_unsigned = 1'b1;
            bus.a = 32'd100; bus.b = 32'd7;
         end
         #1;
         if (bus.done) begin
            if (d1 < 0) begin
               d1 = c;
               chk("b2b_op1_lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);
               chk("b2b_op1_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
               chk("b2b_stall_in_done", {63'd0, bus.stall}, 64'd1);
            end else if (d2 < 0) begin
               d2 = c;
            end
         end
         if (d2 >= 0) break;
         step();
      end
      chk("b2b_done1_cyc", 64'(d1), 64'd34);
      chk("b2b_done2_cyc", 64'(d2), 64'd68);
      chk("b2b_op2_lo", {32'd0, bus.lo}, 64'd14);
      chk("b2b_op2_hi", {32'd0, bus.hi}, 64'd2);
      chk("b2b_op2_dz", {63'd0, bus.div_zero}, 64'd0);
      bus.start = 1'b0;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: start  in  1  request a MULT/DIV operation this cycle.
REQ-004 SHALL have: op  in  1  0=MULT, 1=DIV (decoded from func 011000/011010).
REQ-005 SHALL have: is_unsigned  in  1  1=unsigned operands, 0=two's-complement.
REQ-006 SHALL have: a  in  32  rs operand (multiplicand/dividend); b  in  32  rt operand (multiplier/divisor).
REQ-007 SHALL have: busy  out  1  operation in progress; stall  out  1  hold pipeline/fetch.
REQ-008 SHALL have: done  out  1  one-cycle pulse, hi/lo valid; div_zero  out  1  last DIV had b==0.
REQ-009 SHALL have: hi  out  32  product[63:32] or remainder; lo  out  32  product[31:0] or quotient.

Function
REQ-010 FSM states SHALL be IDLE, RUN, FIX, DONE.
REQ-011 start SHALL be accepted only in IDLE or DONE; operands, op and is_unsigned latched at acceptance; start in RUN/FIX ignored.
REQ-012 Accept in cycle 0 -> RUN cycles 1..32 (32 iterations, 5-bit counter 0..31) -> FIX cycle 33 -> DONE cycle 34.
REQ-013 RUN/MULT: shift-add on operand magnitudes, one multiplier bit per cycle, 64-bit accumulator.
REQ-014 RUN/DIV: restoring division on magnitudes, one quotient bit per cycle, 33-bit partial remainder.
REQ-015 FIX SHALL apply signs (signed only): product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign.
REQ-016 Signed DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 (wrap, no flag).
REQ-017 DIV with latched b==0 SHALL skip RUN: FIX in cycle 1, DONE in cycle 2; lo=0xFFFFFFFF, hi=a, div_zero=1.
REQ-018 hi/lo SHALL update only on entry to DONE and hold until next DONE; div_zero updates with hi/lo.
REQ-019 done SHALL be 1 exactly in DONE; DONE lasts one cycle, then IDLE unless start accepted (back-to-back allowed).
REQ-020 busy SHALL be 1 in RUN and FIX; stall SHALL equal busy OR (start AND state in {IDLE, DONE}).

Reset
REQ-021 reset SHALL override all inputs incl. start in same cycle; state=IDLE, counter=0.
REQ-022 Reset values: busy=0, stall=0, done=0, div_zero=0, hi=0, lo=0.
REQ-023 reset mid-RUN/FIX SHALL abandon the operation with no done pulse and no hi/lo update.

Configuration
REQ-024 Macro MD_EARLY_TERM_EN defined: MULT RUN SHALL end after the iteration in which the remaining unshifted multiplier magnitude becomes 0 (min 1 RUN cycle, max 32).
REQ-025 MD_EARLY_TERM_EN undefined: MULT always 32 RUN cycles; DIV latency unaffected either way.

Structure
REQ-026 Package md_pkg SHALL hold: state enum, op encoding (MD_MULT/MD_DIV), MD_WIDTH=32, MD_ITERS=32.
REQ-027 One sub-module md_iter_unit SHALL implement the single-cycle shift-add/restore step; md_sequencer owns FSM, counter, sign fix, result registers.

Verification
REQ-028 Unsigned MULT a=0xFFFFFFFF, b=2, start cycle 0 -> done cycle 34, hi=0x00000001, lo=0xFFFFFFFE, busy cycles 1..33.
REQ-029 Signed MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; with MD_EARLY_TERM_EN, done in cycle 5.
REQ-030 Signed DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0, done cycle 34.
REQ-031 DIV a=0x1234, b=0 -> done cycle 2, lo=0xFFFFFFFF, hi=0x1234, div_zero=1.
REQ-032 reset high in cycle 10 of a MULT -> cycle 11 busy=0, hi=lo=0, no done; new start cycle 12 completes cycle 46.
REQ-033 start held in DONE of op1 -> op2 accepted, done pulses cycles 34 and 68; start during RUN ignored.
